axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
- AXI4 full slave with an internal byte-addressable word memory. It is the responder end of the DMA master's AR/R/AW/W/B channels.
- Serves INCR bursts up to 256 beats on independent read and write engines. Used as src/dst memory model in DMA system benches and as on-chip scratch RAM.
- One outstanding transaction per direction; no reordering.

Parameters:
- AXI_ID_WIDTH, 4, width of ARID/RID/AWID/BID.
- ADDR_WIDTH, 32, byte address width.
- AXI_DATA_WIDTH, 32, data bus width in bits; power of two, >= 8.
- MEM_DEPTH, 1024, number of data words; power of two.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- S_AXI_ARID  in  AXI_ID_WIDTH  read ID.
- S_AXI_ARADDR  in  ADDR_WIDTH  read start byte address.
- S_AXI_ARLEN  in  8  beats-1.
- S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RID  out  AXI_ID_WIDTH; S_AXI_RDATA  out  AXI_DATA_WIDTH; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- S_AXI_AWID  in  AXI_ID_WIDTH; S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWLEN  in  8; S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  AXI_DATA_WIDTH; S_AXI_WSTRB  in  AXI_DATA_WIDTH/8; S_AXI_WLAST  in  1; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BID  out  AXI_ID_WIDTH; S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS and the AW equivalents are not ports; full size, INCR is implied.

Behaviour:
- Reset (rst=1 at an edge) puts both FSMs in IDLE with ARREADY=1, AWREADY=1, RVALID=0, RLAST=0, WREADY=0, BVALID=0, RID/BID/RRESP/BRESP/RDATA=0. Memory contents are not cleared.
- Reset mid-burst aborts the burst immediately. No B is issued for the aborted write; beats already written stay in memory.
- Word index = addr[ADDR_WIDTH-1 : log2(AXI_DATA_WIDTH/8)]. Low byte-offset bits are ignored, so unaligned addresses are aligned down.
- Each beat increments the word index by 1. Beat counter is 8 bits; burst length = LEN+1.
- Read FSM, R_IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY: latch ID, index, LEN; load RDATA<=mem[index]; go to R_DATA.
- Read FSM, R_DATA:
  - ARREADY=0, RVALID=1, RID=latched ID, RLAST=(beat==LEN).
  - RDATA/RLAST held stable while RVALID&!RREADY.
  - On handshake of a non-last beat: RDATA<=mem[index+1], beat++.
  - On handshake of the last beat: RVALID<=0, go to R_IDLE.
  - AR-to-first-RVALID latency = 1 cycle; back-to-back beats with RREADY=1; one idle cycle between bursts.
- Write FSM, W_IDLE:
  - AWREADY=1, WREADY=0.
  - On AW handshake: latch ID, index, LEN; go to W_DATA. W beats presented before AW are stalled (WREADY=0).
- Write FSM, W_DATA:
  - AWREADY=0, WREADY=1.
  - On WVALID&WREADY: write each byte lane whose WSTRB bit is 1, then index++, beat++.
  - The beat counter is authoritative and WLAST is ignored: burst ends after LEN+1 beats; any extra beats wait for the next AW.
  - After the final beat: WREADY<=0, BVALID<=1, BID=latched ID, go to W_RESP.
- Write FSM, W_RESP:
  - Hold BVALID/BID/BRESP until BREADY, then BVALID<=0, go to W_IDLE.
  - Last-W-to-BVALID latency = 1 cycle.
- Read and write run fully concurrently.
- Same word read-loaded and written at the same edge: RDATA captures the pre-write value (read-first).
- RRESP=BRESP=2'b00 (OKAY) unless the optional feature flags an error.

Optional Feature:
- Macro AXI_SLV_MEM_ERR_EN.
- Defined: a beat whose word index >= MEM_DEPTH (before any modulo) is flagged out of range.
  - Read beat: RDATA=0, RRESP=2'b10 (SLVERR) for that beat.
  - Write beat: write suppressed; a sticky flag sets BRESP=2'b10 for the whole burst.
- Undefined: the index wraps modulo MEM_DEPTH, all responses are OKAY, and the error logic is absent.

Decomposition:
- Shared package pkg.vh: AXI_ID_WIDTH, ADDR_WIDTH, AXI_DATA_WIDTH defaults; RESP_OKAY=2'b00, RESP_SLVERR=2'b10; R_IDLE/R_DATA and W_IDLE/W_DATA/W_RESP encodings.
- Sub-module axi_slave_mem_ram: dual-port register array, one synchronous read port, one byte-enable write port, read-first, MEM_DEPTH x AXI_DATA_WIDTH.

Test Plan:
- Preload mem[0..7]=0x10..0x17; AR addr 0x0, LEN=7, ID=3, RREADY=1 -> RVALID 1 cycle after AR; RDATA 0x10..0x17 on 8 consecutive cycles; RLAST only on 0x17; RID=3.
- AW addr 0x40, LEN=3, ID=5; WDATA 0xA0..0xA3, WSTRB=0xF -> mem[16..19]=0xA0..0xA3; BVALID 1 cycle after 4th beat; BID=5, BRESP=0.
- Write WSTRB=0x5 with WDATA=0xAABBCCDD onto 0x11223344 -> word becomes 0x11BB33DD.
- Read LEN=3 with RREADY toggling 1,0,0,1... -> RDATA/RLAST stable during stalls; 4 beats delivered in order.
- Concurrent read and write of the same addresses, plus rst asserted mid write burst after beat 2 of 4 -> read unaffected before reset; after reset BVALID=0, AWREADY=1, beats 0-1 persist.
- Index MEM_DEPTH-1, LEN=1 -> with AXI_SLV_MEM_ERR_EN: 2nd beat RRESP=2, RDATA=0. Without it: 2nd beat returns mem[0], RRESP=0.

Source files
------------

// File: rtl/axi_slave_mem_pkg.sv
// Shared types and constants for the AXI4 slave memory.
package axi_slave_mem_pkg;

   localparam int AXI_ID_WIDTH_DEF   = 4;
   localparam int ADDR_WIDTH_DEF     = 32;
   localparam int AXI_DATA_WIDTH_DEF = 32;
   localparam int MEM_DEPTH_DEF      = 1024;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'b00,
      W_DATA = 2'b01,
      W_RESP = 2'b10
   } w_state_e;

endpackage

// File: rtl/axi_slave_mem_ram.sv
// Word array with one synchronous read port and one byte-enable write port.
// Read-first: a same-edge read of a written word returns the old value.
module axi_slave_mem_ram #(
   parameter  int DW    = 32,
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH),
   localparam int SW    = DW / 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [SW-1:0] wstrb_i,
   input  logic [DW-1:0] wdata_i
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < SW; b++) begin
            if (wstrb_i[b]) begin
               mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave memory with independent read and write engines.
// Define AXI_SLV_MEM_ERR_EN to flag beats beyond MEM_DEPTH with SLVERR.
module axi_slave_mem
   import axi_slave_mem_pkg::*;
#(
   parameter int AXI_ID_WIDTH   = AXI_ID_WIDTH_DEF,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
   parameter int MEM_DEPTH      = MEM_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_ARADDR,
   input  logic [7:0]                  S_AXI_ARLEN,
   input  logic                        S_AXI_ARVALID,
   output logic                        S_AXI_ARREADY,
   output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
   output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                  S_AXI_RRESP,
   output logic                        S_AXI_RLAST,
   output logic                        S_AXI_RVALID,
   input  logic                        S_AXI_RREADY,
   input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [ADDR_WIDTH-1:0]       S_AXI_AWADDR,
   input  logic [7:0]                  S_AXI_AWLEN,
   input  logic                        S_AXI_AWVALID,
   output logic                        S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                        S_AXI_WLAST,
   input  logic                        S_AXI_WVALID,
   output logic                        S_AXI_WREADY,
   output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                  S_AXI_BRESP,
   output logic                        S_AXI_BVALID,
   input  logic                        S_AXI_BREADY
);

   localparam int OFFW = $clog2(AXI_DATA_WIDTH / 8);
   localparam int IDXW = ADDR_WIDTH - OFFW;
   localparam int MAW  = $clog2(MEM_DEPTH);

   r_state_e                r_state_q, r_state_d;
   logic [IDXW-1:0]         ridx_q, ridx_d, rnext;
   logic [7:0]              rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
   logic                    ram_re;
   logic [AXI_DATA_WIDTH-1:0] ram_rdata;

   w_state_e                w_state_q, w_state_d;
   logic [IDXW-1:0]         widx_q, widx_d;
   logic [7:0]              wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
   logic                    aw_hs, w_hs, w_last, ram_we;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_WLAST,
                        ridx_q, widx_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rid_q     <= '0;
         w_state_q <= W_IDLE;
         widx_q    <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         bid_q     <= '0;
      end else begin
         r_state_q <= r_state_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rid_q     <= rid_d;
         w_state_q <= w_state_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         bid_q     <= bid_d;
      end
   end

   // rnext is the word fetched at this edge: first beat or the one after.
   always_comb begin
      r_state_d = r_state_q;
      ridx_d    = ridx_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rid_d     = rid_q;
      rnext     = ridx_q;
      ram_re    = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (S_AXI_ARVALID) begin
               rnext     = S_AXI_ARADDR[ADDR_WIDTH-1:OFFW];
               ram_re    = 1'b1;
               ridx_d    = rnext;
               rlen_d    = S_AXI_ARLEN;
               rbeat_d   = 8'd0;
               rid_d     = S_AXI_ARID;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               if (rbeat_q == rlen_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rnext   = ridx_q + 1'b1;
                  ram_re  = 1'b1;
                  ridx_d  = rnext;
                  rbeat_d = rbeat_q + 8'd1;
               end
            end
         end
      endcase
   end

   assign aw_hs  = (w_state_q == W_IDLE) && S_AXI_AWVALID;
   assign w_hs   = (w_state_q == W_DATA) && S_AXI_WVALID;
   assign w_last = w_hs && (wbeat_q == wlen_q);

   always_comb begin
      w_state_d = w_state_q;
      widx_d    = widx_q;
      wlen_d    = wlen_q;
      wbeat_d   = wbeat_q;
      bid_d     = bid_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               widx_d    = S_AXI_AWADDR[ADDR_WIDTH-1:OFFW];
               wlen_d    = S_AXI_AWLEN;
               wbeat_d   = 8'd0;
               bid_d     = S_AXI_AWID;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               widx_d  = widx_q + 1'b1;
               wbeat_d = wbeat_q + 8'd1;
               if (w_last) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

`ifdef AXI_SLV_MEM_ERR_EN
   logic       rerr_q, rerr_d, woor, werr_q, werr_d;
   logic [1:0] bresp_q, bresp_d;

   assign woor = (widx_q >= IDXW'(MEM_DEPTH));

   always_comb begin
      rerr_d  = rerr_q;
      werr_d  = werr_q;
      bresp_d = bresp_q;
      if (ram_re) rerr_d = (rnext >= IDXW'(MEM_DEPTH));
      if (aw_hs) werr_d = 1'b0;
      else if (w_hs) werr_d = werr_q | woor;
      if (w_last) bresp_d = (werr_q | woor) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rerr_q  <= 1'b0;
         werr_q  <= 1'b0;
         bresp_q <= RESP_OKAY;
      end else begin
         rerr_q  <= rerr_d;
         werr_q  <= werr_d;
         bresp_q <= bresp_d;
      end
   end

   assign ram_we      = w_hs && !woor;
   assign S_AXI_RDATA = rerr_q ? '0 : ram_rdata;
   assign S_AXI_RRESP = rerr_q ? RESP_SLVERR : RESP_OKAY;
   assign S_AXI_BRESP = bresp_q;
`else
   assign ram_we      = w_hs;
   assign S_AXI_RDATA = ram_rdata;
   assign S_AXI_RRESP = RESP_OKAY;
   assign S_AXI_BRESP = RESP_OKAY;
`endif

   axi_slave_mem_ram #(
      .DW    (AXI_DATA_WIDTH),
      .DEPTH (MEM_DEPTH)
   ) u_ram (
      .clk_i   (clk),
      .rst_i   (rst),
      .re_i    (ram_re),
      .raddr_i (rnext[MAW-1:0]),
      .rdata_o (ram_rdata),
      .we_i    (ram_we),
      .waddr_i (widx_q[MAW-1:0]),
      .wstrb_i (S_AXI_WSTRB),
      .wdata_i (S_AXI_WDATA)
   );

   assign S_AXI_ARREADY = (r_state_q == R_IDLE);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RLAST   = S_AXI_RVALID && (rbeat_q == rlen_q);
   assign S_AXI_RID     = rid_q;
   assign S_AXI_AWREADY = (w_state_q == W_IDLE);
   assign S_AXI_WREADY  = (w_state_q == W_DATA);
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BID     = bid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: directed bursts, R/B checked by a monitor.
module tb_axi_slave_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arid, rid, awid, bid;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [7:0]  arlen, awlen;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready;
   logic        bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   axi_slave_mem dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_ARID    (arid),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARLEN   (arlen),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RID     (rid),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RLAST   (rlast),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .S_AXI_AWID    (awid),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWLEN   (awlen),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WLAST   (wlast),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BID     (bid),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready)
   );

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic [3:0]  id;
      logic [1:0]  resp;
   } rexp_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   rexp_t re_;
   bexp_t be_;
   int    n_tests = 0;
   int    n_fail  = 0;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   // Monitor: scoreboard pops and stall-stability checks.
   logic        stall_q = 1'b0;
   logic [31:0] pd;
   logic        pl;

   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", {rdata, rlast}, {pd, pl});
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) fail("r_unexpected");
            else begin
               re_ = rq.pop_front();
               check("r_beat", {rdata, rlast, rid, rresp}, re_);
            end
         end
         stall_q = rvalid && !rready;
         pd = rdata;
         pl = rlast;
         if (bvalid && bready) begin
            if (bq.size() == 0) fail("b_unexpected");
            else begin
               be_ = bq.pop_front();
               check("b_resp", {bid, bresp}, be_);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic er(input logic [31:0] d, input logic l,
                     input logic [3:0] id, input logic [1:0] resp);
      rq.push_back({d, l, id, resp});
   endtask

   task automatic wr(input logic [31:0] addr, input logic [7:0] len,
                     input logic [3:0] id, input logic [31:0] base,
                     input logic [3:0] strb, input logic [1:0] resp);
      int t;
      bq.push_back({id, resp});
      awvalid = 1'b1;
      awaddr  = addr;
      awlen   = len;
      awid    = id;
      t = 0;
      while (!awready && t < 50) begin tick(); t++; end
      if (!awready) fail("aw_timeout");
      tick();
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1'b1;
         wdata  = base + 32'(i);
         wstrb  = strb;
         wlast  = (i == int'(len));
         t = 0;
         while (!wready && t < 50) begin tick(); t++; end
         if (!wready) fail("w_timeout");
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      check("b_latency", bvalid, 1);
      t = 0;
      while (bq.size() != 0 && t < 50) begin tick(); t++; end
      if (bq.size() != 0) fail("b_timeout");
   endtask

   task automatic rd(input logic [31:0] addr, input logic [7:0] len,
                     input logic [3:0] id, input logic [15:0] pat,
                     input int exp_cyc);
      int t, cyc, k;
      arvalid = 1'b1;
      araddr  = addr;
      arlen   = len;
      arid    = id;
      t = 0;
      while (!arready && t < 50) begin tick(); t++; end
      if (!arready) fail("ar_timeout");
      tick();
      arvalid = 1'b0;
      check("r_latency", rvalid, 1);
      cyc = 0;
      k   = 0;
      while (rq.size() != 0 && cyc < 300) begin
         rready = pat[k % 16];
         k++;
         tick();
         cyc++;
      end
      rready = 1'b0;
      if (rq.size() != 0) fail("r_timeout");
      if (exp_cyc != 0) check("r_burst_cycles", cyc, exp_cyc);
   endtask

   initial begin
      int t;
      rst = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      tick();
      tick();
      check("rst_arready", arready, 1);
      check("rst_awready", awready, 1);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_ids", {rid, bid}, 0);
      check("rst_resps", {rresp, bresp}, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      tick();

      // Preload words 0..7, then an 8-beat read at full rate.
      wr(32'h0, 8'd7, 4'd1, 32'h10, 4'hF, OK);
      for (int i = 0; i < 8; i++) er(32'h10 + 32'(i), i == 7, 4'd3, OK);
      rd(32'h0, 8'd7, 4'd3, 16'hFFFF, 8);

      // Write 4 beats at 0x40, read back with RREADY stalls.
      wr(32'h40, 8'd3, 4'd5, 32'hA0, 4'hF, OK);
      for (int i = 0; i < 4; i++) er(32'hA0 + 32'(i), i == 3, 4'd6, OK);
      rd(32'h40, 8'd3, 4'd6, 16'h9999, 8);

      // Byte strobes, plus an unaligned read address.
      wr(32'h80, 8'd0, 4'd2, 32'h11223344, 4'hF, OK);
      wr(32'h80, 8'd0, 4'd2, 32'hAABBCCDD, 4'h5, OK);
      er(32'h11BB33DD, 1'b1, 4'd4, OK);
      rd(32'h80, 8'd0, 4'd4, 16'hFFFF, 1);
      er(32'h11BB33DD, 1'b1, 4'd4, OK);
      rd(32'h83, 8'd0, 4'd4, 16'hFFFF, 1);

      // Concurrent read/write of 0x100..0x10C, then reset mid write.
      wr(32'h100, 8'd3, 4'd1, 32'hB0, 4'hF, OK);
      for (int i = 0; i < 4; i++) er(32'hB0 + 32'(i), i == 3, 4'd2, OK);
      rready  = 1'b1;
      awvalid = 1'b1; awaddr = 32'h100; awlen = 8'd3; awid = 4'd7;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b1; wdata = 32'hC0; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h100; arlen = 8'd3; arid = 4'd2;
      tick();
      arvalid = 1'b0;
      wdata   = 32'hC1;
      check("cc_r_latency", rvalid, 1);
      tick();
      wvalid = 1'b0;
      t = 0;
      while (rq.size() != 0 && t < 50) begin tick(); t++; end
      if (rq.size() != 0) fail("cc_r_timeout");
      rready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("abort_bvalid", bvalid, 0);
      check("abort_awready", awready, 1);
      check("abort_wready", wready, 0);
      check("abort_rvalid", rvalid, 0);
      rst = 1'b0;
      tick();
      er(32'hC0, 1'b0, 4'd2, OK);
      er(32'hC1, 1'b0, 4'd2, OK);
      er(32'hB2, 1'b0, 4'd2, OK);
      er(32'hB3, 1'b1, 4'd2, OK);
      rd(32'h100, 8'd3, 4'd2, 16'hFFFF, 4);

      // Top-of-memory boundary: last word then one past it.
      wr(32'hFFC, 8'd0, 4'd3, 32'h5A5A, 4'hF, OK);
      er(32'h5A5A, 1'b0, 4'd8, OK);
`ifdef AXI_SLV_MEM_ERR_EN
      er(32'h0, 1'b1, 4'd8, ERR);
`else
      er(32'h10, 1'b1, 4'd8, OK);
`endif
      rd(32'hFFC, 8'd1, 4'd8, 16'hFFFF, 2);
`ifdef AXI_SLV_MEM_ERR_EN
      wr(32'hFFC, 8'd1, 4'd9, 32'h77, 4'hF, ERR);
      er(32'h10, 1'b1, 4'd10, OK);
`else
      wr(32'hFFC, 8'd1, 4'd9, 32'h77, 4'hF, OK);
      er(32'h78, 1'b1, 4'd10, OK);
`endif
      rd(32'h0, 8'd0, 4'd10, 16'hFFFF, 1);
      er(32'h77, 1'b1, 4'd11, OK);
      rd(32'hFFC, 8'd0, 4'd11, 16'hFFFF, 1);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
